// File: rtl/scr1_wb_dmem_initiator_if.sv
// Bundle of the core data-memory port and the Wishbone initiator port.
// Handshakes:
//   Core side: a request transfers on a clock edge where dmem_req and
//   dmem_req_ack are both high. The response is the single cycle in which
//   dmem_resp is non-zero (1 = OK, 2 = error).
//   Wishbone side: wbd_stb_o stays high, with address/data/selects stable,
//   until the cycle in which wbd_ack_i or wbd_err_i is sampled high.
interface scr1_wb_dmem_initiator_if #(
    parameter int AW = 32
);
    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;

    logic          wbd_stb_o;
    logic [AW-1:0] wbd_adr_o;
    logic          wbd_we_o;
    logic [31:0]   wbd_dat_o;
    logic [3:0]    wbd_sel_o;
    logic [31:0]   wbd_dat_i;
    logic          wbd_ack_i;
    logic          wbd_err_i;

    logic          timeout_o;

    // Initiator side: consumes core requests and Wishbone responses.
    modport master (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output wbd_stb_o, wbd_adr_o, wbd_we_o, wbd_dat_o, wbd_sel_o,
        input  wbd_dat_i, wbd_ack_i, wbd_err_i,
        output timeout_o
    );

    // Environment side: the core plus the Wishbone responder.
    modport slave (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  wbd_stb_o, wbd_adr_o, wbd_we_o, wbd_dat_o, wbd_sel_o,
        output wbd_dat_i, wbd_ack_i, wbd_err_i,
        input  timeout_o
    );
endinterface

// File: rtl/scr1_wb_dmem_initiator.sv
// Wishbone initiator for the core data-memory port: one transaction at a
// time, byte-lane steering, misalignment rejection and a bus timeout.
module scr1_wb_dmem_initiator #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    scr1_wb_dmem_initiator_if.master  bus,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    // Counter is sized to hold TIMEOUT_CYCLES; a 1-bit stub when disabled.
    localparam int             CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [1:0]    state;
    logic [1:0]    width_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt;

    logic          stb_q;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic [31:0]   rdata_q;
    logic [1:0]    resp_q;
    logic          timeout_q;

    logic          accept;
    logic [1:0]    req_off;
    logic          req_misaligned;
    logic [3:0]    req_sel;
    logic [31:0]   req_dat;
    logic [31:0]   rd_shifted;
    logic [31:0]   rd_value;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic          bus_ack;
    logic          bus_err;

    assign accept         = bus.dmem_req && (state == ST_IDLE);
    assign req_off        = bus.dmem_addr[1:0];
    assign cnt_inc        = cnt + 1'b1;
    assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);
    // Terminations only count while the strobe is actually out.
    assign bus_ack        = bus.wbd_ack_i && stb_q;
    assign bus_err        = bus.wbd_err_i && stb_q;

    // Classify the incoming request and steer its write data onto byte lanes.
    always_comb begin
        req_misaligned = 1'b0;
        req_sel        = 4'b0000;
        req_dat        = bus.dmem_wdata << {req_off, 3'b000};
        case (bus.dmem_width)
            2'd0: begin
                req_sel = 4'b0001 << req_off;
            end
            2'd1: begin
                req_misaligned = req_off[0];
                req_sel        = 4'b0011 << req_off;
            end
            2'd2: begin
                req_misaligned = (req_off != 2'd0);
                req_sel        = 4'b1111;
                req_dat        = bus.dmem_wdata;
            end
            default: begin
                req_misaligned = 1'b1;
            end
        endcase
    end

    // Right-justify and zero-extend the read lanes of the current transfer.
    always_comb begin
        rd_shifted = bus.wbd_dat_i >> {off_q, 3'b000};
        case (width_q)
            2'd0:    rd_value = {24'd0, rd_shifted[7:0]};
            2'd1:    rd_value = {16'd0, rd_shifted[15:0]};
            default: rd_value = rd_shifted;
        endcase
    end

    // Transaction FSM together with the registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            width_q   <= 2'd0;
            off_q     <= 2'd0;
            cnt       <= '0;
            stb_q     <= 1'b0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            rdata_q   <= 32'd0;
            resp_q    <= RESP_NONE;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        width_q <= bus.dmem_width;
                        off_q   <= req_off;
                        if (req_misaligned) begin
                            resp_q <= RESP_ERR;
                            state  <= ST_RESP;
                        end else begin
                            stb_q <= 1'b1;
                            adr_q <= {bus.dmem_addr[AW-1:2], 2'b00};
                            we_q  <= bus.dmem_cmd;
                            sel_q <= req_sel;
                            dat_q <= req_dat;
                            state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_err) begin
                        stb_q   <= 1'b0;
                        resp_q  <= RESP_ERR;
                        rdata_q <= 32'd0;
                        state   <= ST_RESP;
                    end else if (bus_ack) begin
                        stb_q  <= 1'b0;
                        resp_q <= RESP_OK;
                        if (!we_q) begin
                            rdata_q <= rd_value;
                        end
                        state <= ST_RESP;
                    end else if (timeout_hit) begin
                        stb_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        resp_q    <= RESP_ERR;
                        state     <= ST_RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RESP: begin
                    resp_q <= RESP_NONE;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    stb_q  <= 1'b0;
                    resp_q <= RESP_NONE;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dmem_req_ack = accept;
    assign bus.dmem_rdata   = rdata_q;
    assign bus.dmem_resp    = resp_q;
    assign bus.wbd_stb_o    = stb_q;
    assign bus.wbd_adr_o    = adr_q;
    assign bus.wbd_we_o     = we_q;
    assign bus.wbd_dat_o    = dat_q;
    assign bus.wbd_sel_o    = sel_q;
    assign bus.timeout_o    = timeout_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_scr1_wb_dmem_initiator.sv
// Bench for scr1_wb_dmem_initiator: directed scenarios plus randomized
// transactions against a byte-lane reference model and an expected queue.
module tb_scr1_wb_dmem_initiator;

    localparam int AW = 32;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    scr1_wb_dmem_initiator_if #(.AW(AW)) bus_if ();

    scr1_wb_dmem_initiator #(
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entry: {check_rdata, resp[1:0], rdata[31:0]}
    logic [34:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_misaligned(input logic [1:0] w, input int off);
        if (w == 2'd3) return 1'b1;
        return (off % nbytes(w)) != 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] w, input int off);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nbytes(w)) s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_wdat(input logic [1:0] w, input int off, input logic [31:0] wd);
        if (w == 2'd2) return wd;
        return wd << (8 * off);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] w, input int off, input logic [31:0] word);
        logic [31:0] r;
        r = 32'd0;
        for (int j = 0; j < nbytes(w); j++) begin
            r[8*j +: 8] = word[8*(off+j) +: 8];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus_if.dmem_req   = 1'b0;
        bus_if.dmem_cmd   = 1'b0;
        bus_if.dmem_width = 2'd0;
        bus_if.dmem_addr  = '0;
        bus_if.dmem_wdata = 32'd0;
        bus_if.wbd_dat_i  = 32'd0;
        bus_if.wbd_ack_i  = 1'b0;
        bus_if.wbd_err_i  = 1'b0;
    endtask

    // term: 0 = ack, 1 = err, 2 = ack+err together, 3 = never respond
    task automatic run_txn(input logic cmd, input logic [1:0] w, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rword,
                           input int term, input string name);
        int          off;
        int          stb_cycles;
        int          limit;
        logic        mis;
        logic [34:0] exp_e;
        logic [34:0] got_e;
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;

        off     = int'(addr[1:0]);
        mis     = model_misaligned(w, off);
        exp_adr = addr & 32'hFFFF_FFFC;
        exp_sel = model_sel(w, off);
        exp_dat = model_wdat(w, off, wdata);

        if (mis || term == 3)            exp_e = {1'b0, 2'd2, 32'd0};
        else if (term == 1 || term == 2) exp_e = {1'b1, 2'd2, 32'd0};
        else if (cmd)                    exp_e = {1'b0, 2'd1, 32'd0};
        else                             exp_e = {1'b1, 2'd1, model_rdata(w, off, rword)};
        exp_q.push_back(exp_e);

        @(negedge clk);
        bus_if.dmem_req   = 1'b1;
        bus_if.dmem_cmd   = cmd;
        bus_if.dmem_width = w;
        bus_if.dmem_addr  = addr;
        bus_if.dmem_wdata = wdata;
        #1;
        n_cmp++;
        if (bus_if.dmem_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ack got=%b exp=1", name, bus_if.dmem_req_ack);
        end

        @(negedge clk);
        bus_if.dmem_req = 1'b0;
        if (mis) begin
            n_cmp++;
            if (bus_if.wbd_stb_o !== 1'b0) begin
                n_fail++; $display("FAIL %s misaligned_stb got=%b exp=0", name, bus_if.wbd_stb_o);
            end
        end else begin
            stb_cycles = 0;
            limit      = (term == 3) ? TO : waits + 1;
            while (bus_if.wbd_stb_o === 1'b1 && stb_cycles < 20) begin
                stb_cycles++;
                n_cmp++;
                if (bus_if.wbd_adr_o !== exp_adr) begin
                    n_fail++; $display("FAIL %s adr got=%h exp=%h", name, bus_if.wbd_adr_o, exp_adr);
                end
                n_cmp++;
                if (bus_if.wbd_sel_o !== exp_sel) begin
                    n_fail++; $display("FAIL %s sel got=%b exp=%b", name, bus_if.wbd_sel_o, exp_sel);
                end
                n_cmp++;
                if (bus_if.wbd_we_o !== cmd) begin
                    n_fail++; $display("FAIL %s we got=%b exp=%b", name, bus_if.wbd_we_o, cmd);
                end
                if (cmd) begin
                    n_cmp++;
                    if (bus_if.wbd_dat_o !== exp_dat) begin
                        n_fail++; $display("FAIL %s dat_o got=%h exp=%h", name, bus_if.wbd_dat_o, exp_dat);
                    end
                end
                n_cmp++;
                if (bus_if.dmem_resp !== 2'd0) begin
                    n_fail++; $display("FAIL %s resp_during_bus got=%0d exp=0", name, bus_if.dmem_resp);
                end
                if (term != 3 && stb_cycles == waits + 1) begin
                    bus_if.wbd_ack_i = (term == 0 || term == 2);
                    bus_if.wbd_err_i = (term == 1 || term == 2);
                    bus_if.wbd_dat_i = rword;
                end else begin
                    bus_if.wbd_dat_i = $urandom;
                end
                @(negedge clk);
                bus_if.wbd_ack_i = 1'b0;
                bus_if.wbd_err_i = 1'b0;
            end
            n_cmp++;
            if (stb_cycles != limit) begin
                n_fail++; $display("FAIL %s stb_cycles got=%0d exp=%0d", name, stb_cycles, limit);
            end
        end

        // Response cycle: compare against the scoreboard head.
        got_e = {1'b0, bus_if.dmem_resp, bus_if.dmem_rdata};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard empty got_resp=%0d exp=entry", name, bus_if.dmem_resp);
        end else begin
            exp_e = exp_q.pop_front();
            if (got_e[33:32] !== exp_e[33:32]) begin
                n_fail++; $display("FAIL %s resp got=%0d exp=%0d", name, got_e[33:32], exp_e[33:32]);
            end
            if (exp_e[34]) begin
                n_cmp++;
                if (got_e[31:0] !== exp_e[31:0]) begin
                    n_fail++; $display("FAIL %s rdata got=%h exp=%h", name, got_e[31:0], exp_e[31:0]);
                end
            end
        end

        @(negedge clk);
        n_cmp++;
        if (bus_if.dmem_resp !== 2'd0) begin
            n_fail++; $display("FAIL %s resp_one_cycle got=%0d exp=0", name, bus_if.dmem_resp);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({bus_if.wbd_stb_o, bus_if.wbd_we_o, bus_if.wbd_sel_o} !== 6'd0) begin
            n_fail++; $display("FAIL %s stb_we_sel got=%b exp=0", name,
                               {bus_if.wbd_stb_o, bus_if.wbd_we_o, bus_if.wbd_sel_o});
        end
        n_cmp++;
        if (bus_if.wbd_adr_o !== 32'd0 || bus_if.wbd_dat_o !== 32'd0) begin
            n_fail++; $display("FAIL %s adr_dat got=%h/%h exp=0/0", name, bus_if.wbd_adr_o, bus_if.wbd_dat_o);
        end
        n_cmp++;
        if (bus_if.dmem_rdata !== 32'd0 || bus_if.dmem_resp !== 2'd0) begin
            n_fail++; $display("FAIL %s rdata_resp got=%h/%0d exp=0/0", name, bus_if.dmem_rdata, bus_if.dmem_resp);
        end
        n_cmp++;
        if (bus_if.timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL %s timeout_o got=%b exp=0", name, bus_if.timeout_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_read();
        run_txn(1'b0, 2'd0, 32'h0000_1003, 32'd0, 0, 32'hA1B2_C3D4, 0, "byte_read");
    endtask

    task automatic test_halfword_write();
        run_txn(1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 3, 32'd0, 0, "hword_write");
    endtask

    // Misaligned reject with dmem_req held high: re-accepted two cycles later.
    task automatic test_back_to_back();
        @(negedge clk);
        bus_if.dmem_req   = 1'b1;
        bus_if.dmem_cmd   = 1'b0;
        bus_if.dmem_width = 2'd2;
        bus_if.dmem_addr  = 32'h0000_3001;
        #1;
        n_cmp++;
        if (bus_if.dmem_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b ack_c0 got=%b exp=1", bus_if.dmem_req_ack);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus_if.wbd_stb_o, bus_if.dmem_resp, bus_if.dmem_req_ack} !== 4'b0100) begin
            n_fail++; $display("FAIL b2b c1 stb_resp_ack got=%b exp=0100",
                               {bus_if.wbd_stb_o, bus_if.dmem_resp, bus_if.dmem_req_ack});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus_if.dmem_resp, bus_if.dmem_req_ack} !== 3'b001) begin
            n_fail++; $display("FAIL b2b c2 resp_ack got=%b exp=001", {bus_if.dmem_resp, bus_if.dmem_req_ack});
        end
        bus_if.dmem_width = 2'd1;
        bus_if.dmem_addr  = 32'h0000_3003;
        @(negedge clk);
        bus_if.dmem_req = 1'b0;
        n_cmp++;
        if ({bus_if.wbd_stb_o, bus_if.dmem_resp} !== 3'b010) begin
            n_fail++; $display("FAIL b2b c3 stb_resp got=%b exp=010", {bus_if.wbd_stb_o, bus_if.dmem_resp});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        n_cmp++;
        if (bus_if.timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pre got=%b exp=0", bus_if.timeout_o);
        end
        run_txn(1'b0, 2'd2, 32'h0000_4000, 32'd0, 0, 32'd0, 3, "timeout");
        n_cmp++;
        if (bus_if.timeout_o !== 1'b1) begin
            n_fail++; $display("FAIL timeout_set got=%b exp=1", bus_if.timeout_o);
        end
        run_txn(1'b0, 2'd2, 32'h0000_4004, 32'd0, 1, 32'h1234_5678, 0, "after_timeout");
        n_cmp++;
        if (bus_if.timeout_o !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky got=%b exp=1", bus_if.timeout_o);
        end
    endtask

    task automatic test_ack_err();
        run_txn(1'b0, 2'd2, 32'h0000_5000, 32'd0, 1, 32'hDEAD_BEEF, 2, "ack_err");
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        bus_if.wbd_ack_i = 1'b1;
        bus_if.wbd_err_i = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.wbd_ack_i = 1'b0;
        bus_if.wbd_err_i = 1'b0;
        n_cmp++;
        if ({bus_if.wbd_stb_o, bus_if.dmem_resp} !== 3'b000) begin
            n_fail++; $display("FAIL stray_ack stb_resp got=%b exp=000", {bus_if.wbd_stb_o, bus_if.dmem_resp});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus_if.dmem_req   = 1'b1;
        bus_if.dmem_cmd   = 1'b1;
        bus_if.dmem_width = 2'd2;
        bus_if.dmem_addr  = 32'h0000_6000;
        bus_if.dmem_wdata = $urandom;
        @(negedge clk);
        bus_if.dmem_req = 1'b0;
        n_cmp++;
        if (bus_if.wbd_stb_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid stb_before got=%b exp=1", bus_if.wbd_stb_o);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        run_txn(1'b0, 2'd2, 32'h0000_0000, 32'd0, 0, $urandom, 0, "after_rst");
    endtask

    task automatic test_random();
        logic        cmd;
        logic [1:0]  w;
        logic [31:0] addr;
        int          sel;
        int          term;
        for (int k = 0; k < 40; k++) begin
            cmd  = 1'($urandom_range(0, 1));
            w    = 2'($urandom_range(0, 3));
            addr = $urandom & 32'h0000_FFFF;
            sel  = $urandom_range(0, 9);
            term = (sel < 7) ? 0 : sel - 6;
            run_txn(cmd, w, addr, $urandom, $urandom_range(0, 3), $urandom, term, "random");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_byte_read();
        test_halfword_write();
        test_back_to_back();
        test_timeout();
        test_ack_err();
        test_stray_ack();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog got=expired exp=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
